// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared definitions for the CPU external bus arbiter: FSM state encodings,
// port-select constants and bus direction constants.
package cpu_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS_A = 2'd1,
    ACCESS_B = 2'd2,
    RELEASE  = 2'd3
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

endpackage

// File: rtl/cpu_bus_arbiter_timeout.sv
// Reusable bus-access watchdog. Counts enabled cycles since the last clear and
// raises o_expired during the TIMEOUT_CYCLES-th enabled cycle, so a master that
// aborts on o_expired keeps its request up for exactly TIMEOUT_CYCLES cycles.
// TIMEOUT_CYCLES = 0 disables the watchdog entirely.
module cpu_bus_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] r_count;
  logic          w_atLimit;

  assign w_atLimit = (r_count == CW'(LIMIT));
  assign o_expired = (TIMEOUT_CYCLES != 0) && w_atLimit;

  // Cycle counter: cleared when a new access is granted, advances while the
  // access is outstanding and parks at the limit.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Two-port CPU external bus arbiter. Port A (instruction fetch) is read-only,
// port B (memory stage) reads or writes. One transaction runs at a time, ties
// are broken round-robin, and every completion or timeout is reported with a
// one-cycle ready pulse. All outputs come straight from registers.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int          ADDR_WIDTH     = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  output logic                  o_bus_rw,
  output logic                  o_bus_request,
  input  logic                  i_bus_ready,
  output logic [ADDR_WIDTH-1:0] o_bus_address,
  input  logic [31:0]           i_bus_rdata,
  output logic [31:0]           o_bus_wdata,
  input  logic                  i_pa_request,
  output logic                  o_pa_ready,
  output logic                  o_pa_error,
  input  logic [ADDR_WIDTH-1:0] i_pa_address,
  output logic [31:0]           o_pa_rdata,
  input  logic                  i_pb_rw,
  input  logic                  i_pb_request,
  output logic                  o_pb_ready,
  output logic                  o_pb_error,
  input  logic [ADDR_WIDTH-1:0] i_pb_address,
  output logic [31:0]           o_pb_rdata,
  input  logic [31:0]           i_pb_wdata
);

  arb_state_t            r_state, w_nextState;
  logic                  r_lastGrant, w_nextLastGrant;
  logic                  r_busRw, w_nextBusRw;
  logic                  r_busRequest, w_nextBusRequest;
  logic [ADDR_WIDTH-1:0] r_busAddress, w_nextBusAddress;
  logic [31:0]           r_busWdata, w_nextBusWdata;
  logic                  r_paReady, w_nextPaReady;
  logic                  r_paError, w_nextPaError;
  logic [31:0]           r_paRdata, w_nextPaRdata;
  logic                  r_pbReady, w_nextPbReady;
  logic                  r_pbError, w_nextPbError;
  logic [31:0]           r_pbRdata, w_nextPbRdata;

  logic w_grantA;
  logic w_grantB;
  logic w_inAccess;
  logic w_expired;
  logic w_finish;

  // On a tie the port that did not win last time gets the bus.
  assign w_grantA   = (r_state == IDLE) && i_pa_request &&
                      (!i_pb_request || (r_lastGrant == PORT_B));
  assign w_grantB   = (r_state == IDLE) && i_pb_request &&
                      (!i_pa_request || (r_lastGrant == PORT_A));
  assign w_inAccess = (r_state == ACCESS_A) || (r_state == ACCESS_B);
  assign w_finish   = i_bus_ready || w_expired;

  cpu_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_grantA || w_grantB),
    .i_enable (w_inAccess),
    .o_expired(w_expired)
  );

  // Next-state and next-output decode; everything holds unless changed, and
  // the ready pulses default low so they last exactly one cycle.
  always_comb begin
    w_nextState      = r_state;
    w_nextLastGrant  = r_lastGrant;
    w_nextBusRw      = r_busRw;
    w_nextBusRequest = r_busRequest;
    w_nextBusAddress = r_busAddress;
    w_nextBusWdata   = r_busWdata;
    w_nextPaReady    = 1'b0;
    w_nextPaError    = r_paError;
    w_nextPaRdata    = r_paRdata;
    w_nextPbReady    = 1'b0;
    w_nextPbError    = r_pbError;
    w_nextPbRdata    = r_pbRdata;

    case (r_state)
      IDLE: begin
        if (w_grantB) begin
          w_nextState      = ACCESS_B;
          w_nextLastGrant  = PORT_B;
          w_nextBusRequest = 1'b1;
          w_nextBusRw      = i_pb_rw;
          w_nextBusAddress = i_pb_address;
          w_nextBusWdata   = i_pb_wdata;
        end else if (w_grantA) begin
          w_nextState      = ACCESS_A;
          w_nextLastGrant  = PORT_A;
          w_nextBusRequest = 1'b1;
          w_nextBusRw      = BUS_READ;
          w_nextBusAddress = i_pa_address;
          w_nextBusWdata   = '0;
        end
      end
      ACCESS_A: begin
        if (w_finish) begin
          w_nextState      = RELEASE;
          w_nextBusRequest = 1'b0;
          w_nextPaReady    = 1'b1;
          w_nextPaError    = !i_bus_ready;
          w_nextPaRdata    = i_bus_ready ? i_bus_rdata : 32'd0;
        end
      end
      ACCESS_B: begin
        if (w_finish) begin
          w_nextState      = RELEASE;
          w_nextBusRequest = 1'b0;
          w_nextPbReady    = 1'b1;
          w_nextPbError    = !i_bus_ready;
          w_nextPbRdata    = i_bus_ready ? i_bus_rdata : 32'd0;
        end
      end
      RELEASE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves last grant at A so B wins the
  // first tie.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_lastGrant  <= PORT_A;
      r_busRw      <= BUS_READ;
      r_busRequest <= 1'b0;
      r_busAddress <= '0;
      r_busWdata   <= '0;
      r_paReady    <= 1'b0;
      r_paError    <= 1'b0;
      r_paRdata    <= '0;
      r_pbReady    <= 1'b0;
      r_pbError    <= 1'b0;
      r_pbRdata    <= '0;
    end else begin
      r_state      <= w_nextState;
      r_lastGrant  <= w_nextLastGrant;
      r_busRw      <= w_nextBusRw;
      r_busRequest <= w_nextBusRequest;
      r_busAddress <= w_nextBusAddress;
      r_busWdata   <= w_nextBusWdata;
      r_paReady    <= w_nextPaReady;
      r_paError    <= w_nextPaError;
      r_paRdata    <= w_nextPaRdata;
      r_pbReady    <= w_nextPbReady;
      r_pbError    <= w_nextPbError;
      r_pbRdata    <= w_nextPbRdata;
    end
  end

  assign o_bus_rw      = r_busRw;
  assign o_bus_request = r_busRequest;
  assign o_bus_address = r_busAddress;
  assign o_bus_wdata   = r_busWdata;
  assign o_pa_ready    = r_paReady;
  assign o_pa_error    = r_paError;
  assign o_pa_rdata    = r_paRdata;
  assign o_pb_ready    = r_pbReady;
  assign o_pb_error    = r_pbError;
  assign o_pb_rdata    = r_pbRdata;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scoreboard bench for cpu_bus_arbiter: requesters and a bus slave are driven
// from one process on the falling clock edge; every expected transaction is
// queued when issued and checked on the bus and at its ready pulse.
module tb_cpu_bus_arbiter;
  import cpu_bus_arbiter_pkg::*;

  localparam int          ADDR_WIDTH     = 32;
  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam int          WAIT_BUDGET    = 400;

  logic                  i_clock = 1'b0;
  logic                  i_reset = 1'b0;
  logic                  o_bus_rw;
  logic                  o_bus_request;
  logic                  i_bus_ready = 1'b0;
  logic [ADDR_WIDTH-1:0] o_bus_address;
  logic [31:0]           i_bus_rdata = '0;
  logic [31:0]           o_bus_wdata;
  logic                  i_pa_request = 1'b0;
  logic                  o_pa_ready;
  logic                  o_pa_error;
  logic [ADDR_WIDTH-1:0] i_pa_address = '0;
  logic [31:0]           o_pa_rdata;
  logic                  i_pb_rw = 1'b0;
  logic                  i_pb_request = 1'b0;
  logic                  o_pb_ready;
  logic                  o_pb_error;
  logic [ADDR_WIDTH-1:0] i_pb_address = '0;
  logic [31:0]           o_pb_rdata;
  logic [31:0]           i_pb_wdata = '0;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } portReq_t;

  typedef struct {
    logic        port;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        error;
    int          cycles;
  } expect_t;

  portReq_t paQueue[$];
  portReq_t pbQueue[$];
  expect_t  scoreboard[$];

  int          checkCount   = 0;
  int          errorCount   = 0;
  int          slaveLatency = 1;
  int          busCycles    = 0;
  bit          scrambleB    = 1'b0;
  bit          strayReady   = 1'b1;
  logic [31:0] lastPaRdata  = '0;
  logic [31:0] lastPbRdata  = '0;

  cpu_bus_arbiter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .ADDR_WIDTH    (ADDR_WIDTH)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .o_bus_rw     (o_bus_rw),
    .o_bus_request(o_bus_request),
    .i_bus_ready  (i_bus_ready),
    .o_bus_address(o_bus_address),
    .i_bus_rdata  (i_bus_rdata),
    .o_bus_wdata  (o_bus_wdata),
    .i_pa_request (i_pa_request),
    .o_pa_ready   (o_pa_ready),
    .o_pa_error   (o_pa_error),
    .i_pa_address (i_pa_address),
    .o_pa_rdata   (o_pa_rdata),
    .i_pb_rw      (i_pb_rw),
    .i_pb_request (i_pb_request),
    .o_pb_ready   (o_pb_ready),
    .o_pb_error   (o_pb_error),
    .i_pb_address (i_pb_address),
    .o_pb_rdata   (o_pb_rdata),
    .i_pb_wdata   (i_pb_wdata)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 i_clock = ~i_clock;

  // Data the modelled slave returns for an address.
  function automatic logic [31:0] slaveData(input logic [31:0] addr);
    return addr ^ 32'hDEADBFEF;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [95:0] actual,
                             input logic [95:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Queue one request on a port and the transaction the arbiter should produce.
  task automatic applyStimulus(input logic port, input logic rw,
                               input logic [31:0] addr, input logic [31:0] wdata);
    portReq_t r;
    expect_t  e;
    r.rw    = (port == PORT_A) ? BUS_READ : rw;
    r.addr  = addr;
    r.wdata = wdata;
    e.port  = port;
    e.rw    = r.rw;
    e.addr  = addr;
    e.wdata = (port == PORT_A) ? 32'd0 : wdata;
    if (slaveLatency == 0 || slaveLatency > int'(TIMEOUT_CYCLES)) begin
      e.error  = 1'b1;
      e.rdata  = 32'd0;
      e.cycles = int'(TIMEOUT_CYCLES);
    end else begin
      e.error  = 1'b0;
      e.rdata  = slaveData(addr);
      e.cycles = slaveLatency;
    end
    if (port == PORT_A) paQueue.push_back(r);
    else pbQueue.push_back(r);
    scoreboard.push_back(e);
  endtask

  // One clock: check completions and bus fields, then drive requesters and slave.
  task automatic stepCycle();
    expect_t  e;
    portReq_t r;
    @(negedge i_clock);
    if (o_pa_ready || o_pb_ready) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpectedReady", 96'({o_pb_ready, o_pa_ready}), 96'd0);
      end else begin
        e = scoreboard.pop_front();
        checkOutput("readyPort", 96'({o_pb_ready, o_pa_ready}),
                    96'((e.port == PORT_B) ? 2'b10 : 2'b01));
        if (e.port == PORT_A) begin
          checkOutput("paRdata", 96'(o_pa_rdata), 96'(e.rdata));
          checkOutput("paError", 96'(o_pa_error), 96'(e.error));
          checkOutput("pbRdataHold", 96'(o_pb_rdata), 96'(lastPbRdata));
          lastPaRdata = e.rdata;
        end else begin
          checkOutput("pbRdata", 96'(o_pb_rdata), 96'(e.rdata));
          checkOutput("pbError", 96'(o_pb_error), 96'(e.error));
          checkOutput("paRdataHold", 96'(o_pa_rdata), 96'(lastPaRdata));
          lastPbRdata = e.rdata;
        end
        checkOutput("busCycles", 96'(busCycles), 96'(e.cycles));
      end
      busCycles = 0;
    end

    if (o_pa_ready) begin
      i_pa_request = 1'b0;
    end else if (!i_pa_request && paQueue.size() > 0) begin
      r = paQueue.pop_front();
      i_pa_address = r.addr;
      i_pa_request = 1'b1;
    end

    if (o_pb_ready) begin
      i_pb_request = 1'b0;
    end else if (!i_pb_request && pbQueue.size() > 0) begin
      r = pbQueue.pop_front();
      i_pb_rw      = r.rw;
      i_pb_address = r.addr;
      i_pb_wdata   = r.wdata;
      i_pb_request = 1'b1;
    end else if (scrambleB && i_pb_request && o_bus_request) begin
      i_pb_address = $urandom;
      i_pb_wdata   = $urandom;
    end

    if (o_bus_request) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpectedBus", 96'(o_bus_request), 96'd0);
      end else begin
        e = scoreboard[0];
        checkOutput("busFields", 96'({o_bus_rw, o_bus_address, o_bus_wdata}),
                    96'({e.rw, e.addr, e.wdata}));
      end
      busCycles++;
      if (slaveLatency != 0 && busCycles == slaveLatency) begin
        i_bus_ready = 1'b1;
        i_bus_rdata = slaveData(o_bus_address);
      end else begin
        i_bus_ready = 1'b0;
        i_bus_rdata = $urandom;
      end
    end else begin
      i_bus_ready = strayReady ? 1'($urandom) : 1'b0;
      i_bus_rdata = $urandom;
    end
  endtask

  // Run until all queued work has completed, bounded by a cycle budget.
  task automatic waitIdle();
    int n = 0;
    while ((scoreboard.size() != 0 || paQueue.size() != 0 || pbQueue.size() != 0)
           && n < WAIT_BUDGET) begin
      stepCycle();
      n++;
    end
    if (n >= WAIT_BUDGET) checkOutput("waitBudget", 96'(scoreboard.size()), 96'd0);
    stepCycle();
    stepCycle();
  endtask

  // Assert reset, flush bench state, check the reset values, then release.
  task automatic doReset();
    i_reset      = 1'b1;
    i_pa_request = 1'b0;
    i_pb_request = 1'b0;
    i_bus_ready  = 1'b0;
    busCycles    = 0;
    scoreboard.delete();
    paQueue.delete();
    pbQueue.delete();
    #1;
    checkOutput("resetCtrl", 96'({o_bus_rw, o_bus_request, o_pa_ready, o_pa_error,
                                  o_pb_ready, o_pb_error}), 96'd0);
    checkOutput("resetBus", 96'({o_bus_address, o_bus_wdata}), 96'd0);
    checkOutput("resetRdata", 96'({o_pa_rdata, o_pb_rdata}), 96'd0);
    stepCycle();
    stepCycle();
    i_reset     = 1'b0;
    lastPaRdata = '0;
    lastPbRdata = '0;
  endtask

  initial begin
    int n;
    #2;
    $display("[TB] start");

    // A alone, slave ready on third request cycle.
    doReset();
    slaveLatency = 3;
    applyStimulus(PORT_A, BUS_READ, 32'h0000_0100, 32'd0);
    waitIdle();

    // Simultaneous A read and B write after reset: B first.
    doReset();
    slaveLatency = 1;
    applyStimulus(PORT_B, BUS_WRITE, 32'h0000_0200, 32'h1234_5678);
    applyStimulus(PORT_A, BUS_READ, 32'h0000_0100, 32'd0);
    waitIdle();

    // Round-robin alternation with both ports busy.
    doReset();
    slaveLatency = 1;
    applyStimulus(PORT_B, BUS_READ, 32'h0000_1000, 32'h1111_1111);
    applyStimulus(PORT_A, BUS_READ, 32'h0000_2000, 32'd0);
    applyStimulus(PORT_B, BUS_WRITE, 32'h0000_1004, 32'h2222_2222);
    applyStimulus(PORT_A, BUS_READ, 32'h0000_2004, 32'd0);
    waitIdle();

    // Timeout and its boundaries, then normal traffic.
    doReset();
    slaveLatency = 0;
    applyStimulus(PORT_B, BUS_READ, 32'h0000_0300, 32'd0);
    waitIdle();
    slaveLatency = 16;
    applyStimulus(PORT_B, BUS_READ, 32'h0000_0304, 32'd0);
    waitIdle();
    slaveLatency = 17;
    applyStimulus(PORT_A, BUS_READ, 32'h0000_0308, 32'd0);
    waitIdle();
    slaveLatency = 2;
    applyStimulus(PORT_A, BUS_READ, 32'h0000_030C, 32'd0);
    waitIdle();

    // Reset in the middle of a B access.
    doReset();
    slaveLatency = 0;
    applyStimulus(PORT_B, BUS_WRITE, 32'h0000_0400, 32'hCAFE_F00D);
    n = 0;
    while (!o_bus_request && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput("reachAccessB", 96'(o_bus_request), 96'd1);
    stepCycle();
    #2;
    i_reset = 1'b1;
    #1;
    checkOutput("resetDropsRequest", 96'(o_bus_request), 96'd0);
    checkOutput("resetNoReady", 96'({o_pa_ready, o_pb_ready}), 96'd0);
    doReset();
    slaveLatency = 2;
    applyStimulus(PORT_B, BUS_READ, 32'h0000_0410, 32'd0);
    applyStimulus(PORT_A, BUS_READ, 32'h0000_0414, 32'd0);
    waitIdle();

    // Port B inputs change during its access; captured values must hold.
    doReset();
    slaveLatency = 5;
    scrambleB    = 1'b1;
    applyStimulus(PORT_B, BUS_WRITE, 32'h0000_0500, 32'h0BAD_F00D);
    waitIdle();
    scrambleB = 1'b0;
    applyStimulus(PORT_B, BUS_READ, 32'h0000_0504, 32'd0);
    waitIdle();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
Shares the single CPU external bus between two requesters. Port A is instruction fetch and is read-only. Port B is the memory stage and can read or write. The block arbitrates round-robin on ties, runs one bus transaction at a time, and returns rdata with a one-cycle ready pulse. A bus timeout stops a stalled slave from hanging the pipeline.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles o_bus_request stays high without i_bus_ready before the access aborts with error; 0 disables the timeout
ADDR_WIDTH, 32, bus/port address width

Ports:
i_clock  in  1  CPU clock, rising edge
i_reset  in  1  asynchronous, active-high reset
o_bus_rw  out  1  0=read, 1=write
o_bus_request  out  1  bus access in progress
i_bus_ready  in  1  slave completes access this cycle
o_bus_address  out  ADDR_WIDTH  access address
i_bus_rdata  in  32  read data, valid with i_bus_ready
o_bus_wdata  out  32  write data
i_pa_request  in  1  fetch request, held until o_pa_ready
o_pa_ready  out  1  one-cycle completion pulse
o_pa_error  out  1  timeout flag, valid with o_pa_ready
i_pa_address  in  ADDR_WIDTH  fetch address
o_pa_rdata  out  32  fetch read data
i_pb_rw  in  1  memory-stage direction
i_pb_request  in  1  memory request, held until o_pb_ready
o_pb_ready  out  1  one-cycle completion pulse
o_pb_error  out  1  timeout flag, valid with o_pb_ready
i_pb_address  in  ADDR_WIDTH  memory address
o_pb_rdata  out  32  memory read data
i_pb_wdata  in  32  memory write data

Behaviour:
- All outputs are registered.
- Reset (async, immediate): state=IDLE; all outputs 0; timeout counter 0; last_grant=A, so B wins the first tie.
- States: IDLE, ACCESS_A, ACCESS_B, RELEASE.
- IDLE:
  - Only A requests -> ACCESS_A. Only B requests -> ACCESS_B.
  - Both request -> grant the port != last_grant.
  - On grant, capture address, rw and wdata. Set o_bus_request=1 from the next cycle. Set last_grant=granted port.
- ACCESS_A: o_bus_rw=0, o_bus_wdata=0.
- ACCESS_B: o_bus_rw=captured rw, o_bus_wdata=captured wdata.
- ACCESS completion: i_bus_ready sampled high at an edge causes, in the next cycle:
  - o_bus_request=0;
  - o_pX_ready=1 for exactly one cycle;
  - o_pX_rdata=i_bus_rdata (latched on writes too);
  - o_pX_error=0;
  - state -> RELEASE.
- Timeout (TIMEOUT_CYCLES>0): counter is cleared on grant and increments each ACCESS cycle. Once o_bus_request has been high TIMEOUT_CYCLES cycles with no ready:
  - drop o_bus_request;
  - pulse o_pX_ready with o_pX_error=1 and o_pX_rdata=0;
  - state -> RELEASE.
- Ready arriving in the same cycle as the timeout limit counts as normal completion.
- RELEASE: exactly one cycle with no grant, then IDLE. The requester drops its request in the ready-pulse cycle, so the same stale request is never re-granted.
- Minimum latency: request at cycle 0 -> o_bus_request at cycle 1 -> if i_bus_ready in cycle 1, o_pX_ready in cycle 2. The next grant decision happens in cycle 3 and its access starts in cycle 4.
- Captured fields ignore port input changes during an access.
- Request dropped mid-access: the access still completes and the ready pulse is still emitted.
- o_pX_rdata holds until that port's next completion.
- i_bus_ready outside ACCESS is ignored.
- Reset mid-access: bus request drops immediately and no ready pulse is emitted for the aborted access.

Decomposition:
- Shared CPU defines include holds: state encodings (IDLE=0, ACCESS_A=1, ACCESS_B=2, RELEASE=3), the port-select constants PORT_A/PORT_B, and the bus rw constants BUS_READ/BUS_WRITE.
- One natural sub-module: cpu_bus_timeout. It is a cycle counter with clear/enable inputs and an expired output, parameterised by TIMEOUT_CYCLES, and is reusable by other bus masters.

Test Plan:
1. A alone reads 0x00000100; slave asserts ready on the 3rd request cycle with 0xDEADBEEF -> o_bus_request high cycles 1-3, rw=0; o_pa_ready pulse in cycle 4 with rdata 0xDEADBEEF, error 0.
2. After reset, A read 0x100 and B write (0x200, 0x12345678) arrive in the same cycle -> B served first (rw=1, wdata 0x12345678), then A after one RELEASE cycle; o_pb_ready precedes o_pa_ready.
3. A held continuously and B re-requests immediately after each ready -> bus grants alternate B, A, B, A across 4 accesses; no port is granted twice in a row.
4. TIMEOUT_CYCLES=16 and the slave never readies a B read of 0x300 -> o_bus_request high exactly 16 cycles, then o_pb_ready=1, o_pb_error=1, o_pb_rdata=0; the next access proceeds normally.
5. i_reset asserted during ACCESS_B -> o_bus_request 0 with no clock edge needed, no o_pb_ready; after release, a simultaneous A+B request grants B.
6. i_pb_address/i_pb_wdata changed during ACCESS_B -> o_bus_address/o_bus_wdata keep their captured values until completion.
